// File: rtl/mux_n_1_arb.sv
// N-to-1 registered multiplexer with valid/ready on every channel.
// Channel choice is either an external select or round-robin among the valid inputs.
module mux_n_1_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_IN     = 4,
  localparam int SEL_W     = $clog2(NUM_IN)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         mode_i,
  input  logic [SEL_W-1:0]             sel_i,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_IN-1:0]            in_valid_i,
  output logic [NUM_IN-1:0]            in_ready_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [SEL_W-1:0]             out_src_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i
);

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_src_q,  out_src_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_W-1:0]      rr_ptr_q,   rr_ptr_d;

  logic                  load_en;
  logic                  xfer;
  logic [NUM_IN-1:0]     grant;
  logic                  gnt_any;
  logic [SEL_W-1:0]      gnt_idx;
  logic [NUM_IN-1:0]     rr_rot;
  logic [DATA_WIDTH-1:0] gnt_data;
  int                    rr_idx;

  assign load_en = !out_valid_q || out_ready_i;

  // Valid vector rotated so bit 0 is the channel at rr_ptr; the first set bit wins.
  assign rr_rot = NUM_IN'({in_valid_i, in_valid_i} >> rr_ptr_q);

  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    if (!mode_i) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel_i == SEL_W'(i) && in_valid_i[i]) begin
          grant[i] = 1'b1;
          gnt_any  = 1'b1;
          gnt_idx  = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (!gnt_any && rr_rot[k]) begin
          gnt_any = 1'b1;
          rr_idx  = int'(rr_ptr_q) + k;
          if (rr_idx >= NUM_IN) rr_idx = rr_idx - NUM_IN;
        end
      end
      for (int j = 0; j < NUM_IN; j++) begin
        if (gnt_any && rr_idx == j) begin
          grant[j] = 1'b1;
          gnt_idx  = SEL_W'(j);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      if (grant[j]) gnt_data = in_data_i[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign in_ready_o = (rst_i || !load_en) ? '0 : grant;
  assign xfer       = !rst_i && load_en && gnt_any;

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_src_d   = gnt_idx;
      out_valid_d = 1'b1;
      if (mode_i) begin
        rr_ptr_d = (gnt_idx == SEL_W'(NUM_IN-1)) ? '0 : gnt_idx + SEL_W'(1);
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign out_valid_o = out_valid_q;

  grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(grant));

endmodule

// File: tb/tb_mux_n_1_arb.sv
// Bench for mux_n_1_arb: a 4-channel and a 3-channel instance share stimulus and are
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_mux_n_1_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  rdy4;
  logic [7:0]  dat4;
  logic [1:0]  src4;
  logic        vld4;
  logic [2:0]  rdy3;
  logic [7:0]  dat3;
  logic [1:0]  src3;
  logic        vld3;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mux_n_1_arb #(.DATA_WIDTH(8), .NUM_IN(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .sel_i(sel),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(rdy4),
    .out_data_o(dat4), .out_src_o(src4), .out_valid_o(vld4), .out_ready_i(out_ready)
  );

  mux_n_1_arb #(.DATA_WIDTH(8), .NUM_IN(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .sel_i(sel),
    .in_data_i(in_data[23:0]), .in_valid_i(in_valid[2:0]), .in_ready_o(rdy3),
    .out_data_o(dat3), .out_src_o(src3), .out_valid_o(vld3), .out_ready_i(out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: per instance (0 -> 4 channels, 1 -> 3 channels) the state after the last edge.
  bit         m_v[2];
  logic [7:0] m_d[2];
  int         m_s[2];
  int         m_p[2];

  function automatic int pick(int n, int ptr, bit md, int s, logic [3:0] v);
    if (!md) return (s < n && v[s]) ? s : -1;
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int n;
      int g;
      bit ld;
      logic [3:0] exp_rdy;
      n = (k == 0) ? 4 : 3;
      if (chk_en) begin
        chk(k == 0 ? "m4_valid" : "m3_valid", k == 0 ? 32'(vld4) : 32'(vld3), 32'(m_v[k]));
        chk(k == 0 ? "m4_data"  : "m3_data",  k == 0 ? 32'(dat4) : 32'(dat3), 32'(m_d[k]));
        chk(k == 0 ? "m4_src"   : "m3_src",   k == 0 ? 32'(src4) : 32'(src3), m_s[k]);
      end
      g  = pick(n, m_p[k], mode, int'(sel), in_valid);
      ld = !m_v[k] || out_ready;
      exp_rdy = '0;
      if (!rst && ld && g >= 0) exp_rdy[g] = 1'b1;
      if (chk_en)
        chk(k == 0 ? "m4_in_ready" : "m3_in_ready", k == 0 ? 32'(rdy4) : 32'(rdy3), 32'(exp_rdy));
      if (rst) begin
        m_v[k] = 1'b0; m_d[k] = '0; m_s[k] = 0; m_p[k] = 0;
      end else if (ld && g >= 0) begin
        m_v[k] = 1'b1;
        m_d[k] = in_data[g*8 +: 8];
        m_s[k] = g;
        if (mode) m_p[k] = (g + 1) % n;
      end else if (out_ready) begin
        m_v[k] = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 1'b0; m_d[k] = '0; m_s[k] = 0; m_p[k] = 0;
    end
    rst = 1'b1; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    in_valid = 4'b1111; in_data = 32'h40302010;

    // Reset / idle
    cyc();
    chk_en = 1'b1;
    chk("rst_in_ready", 32'(rdy4), 32'h0);
    cyc();
    chk("rst_out_valid", 32'(vld4), 32'h0);
    chk("rst_out_data", 32'(dat4), 32'h00);
    chk("rst_out_src", 32'(src4), 32'h0);
    chk("rst_in_ready2", 32'(rdy4), 32'h0);

    // Direct select of channel 2
    rst = 1'b0; mode = 1'b0; sel = 2'd2;
    settle();
    chk("dir_in_ready", 32'(rdy4), 32'b0100);
    cyc();
    chk("dir_out_valid", 32'(vld4), 32'h1);
    chk("dir_out_data", 32'(dat4), 32'h30);
    chk("dir_out_src", 32'(src4), 32'h2);
    chk("dir_in_ready_sustain", 32'(rdy4), 32'b0100);
    cyc();
    chk("dir_sustain_valid", 32'(vld4), 32'h1);

    // Round-robin fairness, pointer still at 0
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rr_seq_src", 32'(src4), 32'(i % 4));
    end
    in_valid = 4'b1001;
    settle();
    chk("rr_ptr_back_to_0", 32'(rdy4), 32'b0001);
    cyc();

    // Skip / wrap: drive pointer to 3 via a channel-2 grant
    in_valid = 4'b0100;
    cyc();
    in_valid = 4'b0010;
    settle();
    chk("rr_wrap_in_ready", 32'(rdy4), 32'b0010);
    cyc();
    chk("rr_wrap_src", 32'(src4), 32'h1);
    in_valid = 4'b0101;
    settle();
    chk("rr_skip_in_ready", 32'(rdy4), 32'b0100);
    cyc();
    chk("rr_skip_src", 32'(src4), 32'h2);

    // Backpressure
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010;
    cyc();
    chk("bp_load_data", 32'(dat4), 32'h20);
    out_ready = 1'b0; sel = 2'd3; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_in_ready", 32'(rdy4), 32'h0);
      cyc();
      chk("bp_hold_data", 32'(dat4), 32'h20);
      chk("bp_hold_valid", 32'(vld4), 32'h1);
    end
    out_ready = 1'b1;
    settle();
    chk("bp_release_in_ready", 32'(rdy4), 32'b1000);
    cyc();
    chk("bp_next_data", 32'(dat4), 32'h40);
    chk("bp_next_src", 32'(src4), 32'h3);

    // Out-of-range select on the 3-channel instance
    settle();
    chk("oor_in_ready", 32'(rdy3), 32'h0);
    cyc();
    cyc();
    chk("oor_out_valid", 32'(vld3), 32'h0);

    // Reset while holding a stalled word
    sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b0;
    cyc();
    chk("mid_loaded", 32'(vld4), 32'h1);
    rst = 1'b1;
    settle();
    chk("mid_rst_in_ready", 32'(rdy4), 32'h0);
    cyc();
    chk("mid_rst_valid4", 32'(vld4), 32'h0);
    chk("mid_rst_valid3", 32'(vld3), 32'h0);
    rst = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      mode      = ($urandom_range(0, 9) < 7);
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    rst = 1'b0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_1_arb.md
Name: mux_n_1_arb

Overview:
- Parametrised N-to-1 registered multiplexer with valid/ready handshakes on every input channel and on the output.
- Channel selection is either direct, driven by an external select, or round-robin arbitration among the valid channels.
- It sits in the datapath wherever several producers share one consumer, such as writeback-source or memory-request merging.
- It replaces fixed-width combinational select trees where backpressure and fairness are required.

Parameters:
- DATA_WIDTH, 8, width of each data channel in bits.
- NUM_IN, 4, number of input channels; legal range 2..16, not required to be a power of two.
- SEL_W (localparam), $clog2(NUM_IN), width of the select and source-index fields.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = direct select, 1 = round-robin arbitration.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  NUM_IN*DATA_WIDTH  concatenated channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; combinational.
- out_data  output  DATA_WIDTH  registered selected data.
- out_src  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - in_ready is forced to all zeros while rst=1.
  - Reset mid-transfer drops any held output word. No input transfer occurs in a reset cycle.
- Load enable: load_en = !out_valid || out_ready. The output register accepts a new word only when load_en=1.
- Grant logic (combinational, one-hot grant vector, at most one bit set):
  - mode=0: grant[sel] = in_valid[sel]. If sel >= NUM_IN, no grant.
  - mode=1: starting at index rr_ptr and ascending with wrap-around at NUM_IN-1 -> 0, the first i with in_valid[i]=1 is granted.
  - No grant if in_valid is all zeros.
- in_ready[i] = load_en && grant[i]. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer from channel g:
  - out_data <= channel g data.
  - out_src <= g.
  - out_valid <= 1.
  - In mode=1, rr_ptr <= (g == NUM_IN-1) ? 0 : g+1.
- Otherwise, if out_ready=1, out_valid <= 0. out_data and out_src hold their last values.
- Output stall: if out_valid=1 && out_ready=0, then out_data, out_src and out_valid hold, and in_ready is all zeros.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 word/cycle when out_ready is held at 1. A simultaneous output drain and input load in the same cycle is allowed.
- rr_ptr behaviour:
  - Updated only on mode=1 transfers.
  - Preserved across mode changes.
  - A mode change takes effect in the same cycle it is applied (grant is combinational).
- Fairness: in mode=1 with all channels continuously valid, grants cycle 0,1,...,NUM_IN-1,0,... Each channel waits at most NUM_IN-1 grants.
- Non-granted channels see in_ready=0 and must hold their data (standard valid/ready rule; the block does not buffer them).
- Data width rules: no arithmetic on data. out_src is zero-extended to SEL_W.

Test Plan:
- Reset/idle (NUM_IN=4, DATA_WIDTH=8): assert rst for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0x00, out_src=0, in_ready=4'b0000 throughout.
- Direct mode:
  - Stimulus: mode=0, sel=2, in_valid=4'b1111, data ch0..3 = 0x10,0x20,0x30,0x40, out_ready=1.
  - Required: in_ready=4'b0100; one cycle later out_valid=1, out_data=0x30, out_src=2; sustained 1 word/cycle.
- Round-robin fairness:
  - Stimulus: mode=1, all four valid for 8 cycles, out_ready=1.
  - Required: out_src sequence 0,1,2,3,0,1,2,3; rr_ptr returns to 0.
- Round-robin skip/wrap:
  - Stimulus: mode=1, rr_ptr=3, in_valid=4'b0010.
  - Required: channel 1 granted, then rr_ptr=2; next, with in_valid=4'b0101, channel 2 is granted.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after a word 0x20 is loaded.
  - Required: out_data=0x20, out_valid=1 held and in_ready=0 during the stall; when out_ready=1, the next word is loaded in that same cycle.
- Out-of-range select / mid-op reset:
  - Stimulus: mode=0, sel=3 with NUM_IN=3, all valid.
  - Required: no grant and out_valid falls to 0 after draining.
  - Stimulus: assert rst while out_valid=1 and out_ready=0.
  - Required: out_valid=0 on the next cycle.
